cereal_rx: RTL and testbench
============================

# cereal_rx

Serial receiver for the 8N1 line driven by the design's serial transmitter. Samples the asynchronous `rx` pin in the `sysclk` domain and validates the start bit at mid-bit. Shifts in 8 data bits LSB first and checks the stop bit. Presents each good byte with a one-cycle `valid` strobe; a bad stop bit raises a one-cycle `frame_err` strobe instead.

## Interface
- `CLKS_PER_BIT`, default 5208: `sysclk` cycles per bit (50 MHz / 9600 baud); must be ≥ 8.
- `sysclk` in 1: sole clock, all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx` in 1: asynchronous serial line, idle high.
- `data` out 8: last good byte; holds until the next good byte.
- `valid` out 1: one-cycle strobe, `data` is new this cycle.
- `frame_err` out 1: one-cycle strobe, stop bit sampled low.
- `busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees only `rx_s`.
- Bit counter `cnt` runs from 0 to CLKS_PER_BIT-1. Bit index `idx` is 3 bits.
- States:
  - IDLE: `rx_s`==0 → START, `cnt`←0.
  - START: at `cnt`==CLKS_PER_BIT/2-1, sample. Sampled 0 → DATA, `cnt`←0, `idx`←0. Sampled 1 → IDLE (glitch, no strobe).
  - DATA: at `cnt`==CLKS_PER_BIT-1, sample into `shift[idx]` and `cnt`←0. When `idx`==7 → STOP, otherwise `idx`++.
  - STOP: at `cnt`==CLKS_PER_BIT-1, sample. Sampled 1: `data`←`shift`, `valid`=1 next cycle, → IDLE. Sampled 0: `frame_err`=1 next cycle, `data` unchanged, → BREAK.
  - BREAK: stay until `rx_s`==1, then → IDLE. A line held low never retriggers START.
- Sample value = `rx_s` in that cycle. The CEREAL_RX_MAJORITY_EN macro changes this (see Configuration).
- Reset (`rst_n`==0 at an edge) overrides every state, including mid-frame. Partial bytes are discarded; no strobe is issued.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0. The FSM is in IDLE; `cnt`, `idx`, `shift` are 0; both synchronizer flops are 1.
- Falling edge on `rx` → START after 2 cycles of synchronizer delay plus 1 cycle of detection.
- Start sample lands half a bit into the start bit. Each following sample is exactly CLKS_PER_BIT cycles after the previous one.
- `valid` / `frame_err` are registered. Each is high for the single cycle after the stop sample.
- `valid` and `frame_err` are never high together.
- The FSM returns to IDLE at mid-stop-bit. A start bit immediately following the stop bit (back-to-back frames) is captured without loss.
- No back-pressure. The consumer must take `data` on the `valid` cycle or before the next `valid`.
- `busy` is combinational from the state register.

## Configuration
- `CEREAL_RX_MAJORITY_EN` defined:
  - A 3-bit history register holds `rx_s` for the current cycle and the two prior cycles.
  - Every sample (start, data, stop) is the majority of those three values, so a single-cycle glitch at a sample point is rejected.
  - Sample points and latency are unchanged.
- Undefined: single sample of `rx_s`, no history register.

## Structure
- Package `cereal_pkg` holds:
  - state enum: IDLE, START, DATA, STOP, BREAK;
  - `CEREAL_CLKS_PER_BIT_DFLT`=5208;
  - `CEREAL_DATA_W`=8.
- Sub-module `cereal_sync`: 2-flop synchronizer, reset value 1, parameterized width. It is natural to reuse for other async inputs such as the transmitter's `start`.
- Counter, shifter and FSM stay in `cereal_rx`.

## Test plan
All runs use CLKS_PER_BIT=16.
- Reset then send 0xA5 as 8N1 → one `valid` pulse with `data`=8'hA5; `frame_err` stays 0; `busy` falls with `valid`.
- Send 0x3C with the stop bit driven 0, then `rx` high after 40 cycles → one `frame_err` pulse, `data` still holds the previous value, FSM leaves BREAK only after `rx` goes high.
- Pull `rx` low for 3 cycles then high → `busy` pulses, no `valid`, no `frame_err`, back to IDLE.
- Send 0x00 then 0xFF back-to-back with a one-bit stop → two `valid` pulses 160 cycles apart, with `data` 8'h00 then 8'hFF.
- Assert `rst_n` low during bit 4 of 0x55, release, then send 0x81 → no strobe for 0x55; `valid` with `data`=8'h81.
- With CEREAL_RX_MAJORITY_EN, invert `rx` for one cycle at the bit-2 sample point of 0x00 → `data`=8'h00. Without the macro, the same stimulus gives `data`=8'h04.

Source files
------------

// File: rtl/cereal_pkg.sv
// Shared types and constants for the cereal serial receiver.
// The majority-vote sampling option is selected with CEREAL_RX_MAJORITY_EN.
package cereal_pkg;

  localparam int CEREAL_CLKS_PER_BIT_DFLT = 5208;
  localparam int CEREAL_DATA_W            = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } cereal_state_e;

endpackage

// File: rtl/cereal_sync.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 1
// so an idle-high line does not look like an edge when reset is released.
module cereal_sync #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cereal_rx.sv
// 8N1 serial receiver: mid-bit sampling, LSB-first shift, stop-bit check.
// Define CEREAL_RX_MAJORITY_EN to take each sample as a 3-cycle majority vote.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit, confirm it is still low
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling the stop bit, strobe valid or frame_err
// BREAK | line held low after a framing error, wait for high
module cereal_rx
  import cereal_pkg::*;
#(
  parameter int CLKS_PER_BIT = CEREAL_CLKS_PER_BIT_DFLT
) (
  input  logic                     i_sysclk,
  input  logic                     i_rst_n,
  input  logic                     i_rx,
  output logic [CEREAL_DATA_W-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_frame_err,
  output logic                     o_busy
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  cereal_state_e            r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [2:0]               r_idx;
  logic [CEREAL_DATA_W-1:0] r_shift;
  logic [CEREAL_DATA_W-1:0] r_data;
  logic                     r_valid;
  logic                     r_ferr;

  cereal_state_e            w_state_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [2:0]               w_idx_nxt;
  logic [CEREAL_DATA_W-1:0] w_shift_nxt;
  logic [CEREAL_DATA_W-1:0] w_data_nxt;
  logic                     w_valid_nxt;
  logic                     w_ferr_nxt;
  logic                     w_rx_s;
  logic                     w_sample;

  cereal_sync #(.W(1)) u_sync (
    .i_clk   (i_sysclk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

`ifdef CEREAL_RX_MAJORITY_EN
  // Current rx_s plus the two previous cycles vote, so sample points do not move.
  logic [1:0] r_hist;

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) r_hist <= 2'b11;
    else          r_hist <= {r_hist[0], w_rx_s};
  end

  assign w_sample = (w_rx_s & r_hist[0]) | (w_rx_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  assign w_sample = w_rx_s;
`endif

  always_ff @(posedge i_sysclk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = w_sample ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_sample;
          if (r_idx == 3'd7) w_state_nxt = STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_sample) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BREAK: begin
        // Exit on the raw synchronized level so a stuck-low line never restarts a frame.
        w_cnt_nxt = '0;
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cereal_rx.sv
// Self-checking bench for cereal_rx at 16 clocks per bit; frames are built as
// bit sequences and strobes are compared to an expected-event queue.
module tb_cereal_rx;

  localparam int CPB = 16;
  localparam int LAT = 9 * CPB + CPB / 2 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  cereal_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_sysclk    (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [7:0] data;
    logic       busy;
  } ev_t;

  typedef struct {
    int         start;
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  ev_t        evq[$];
  exp_t       expq[$];
  logic [7:0] last_good;
  int         checks = 0;
  int         errors = 0;
  int         overlap = 0;
  bit         busy_seen;

  always @(negedge clk) begin
    ev_t e;
    if (o_valid || o_frame_err) begin
      e.cyc    = cyc;
      e.is_err = o_frame_err;
      e.data   = o_data;
      e.busy   = o_busy;
      evq.push_back(e);
    end
    if (o_valid && o_frame_err) overlap++;
    if (o_busy) busy_seen = 1'b1;
  end

  task automatic idle(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // Drives one 8N1 frame; glitch_at inverts the line for one cycle, abort_at cuts it short.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int glitch_at,
                            input int abort_at);
    logic [9:0] bits;
    logic [7:0] eb;
    int         t0;
    exp_t       x;
    bits = {stop, b, 1'b0};
    t0   = 0;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == abort_at) return;
      if (c == 0) t0 = cyc;
      rx = bits[c / CPB] ^ (c == glitch_at);
    end
    eb = b;
`ifndef CEREAL_RX_MAJORITY_EN
    if (glitch_at >= CPB && glitch_at < 9 * CPB && (glitch_at % CPB) == CPB / 2)
      eb[glitch_at / CPB - 1] = ~eb[glitch_at / CPB - 1];
`endif
    x.start = t0;
    if (stop) begin
      x.is_err  = 1'b0;
      x.data    = eb;
      last_good = eb;
    end else begin
      x.is_err = 1'b1;
      x.data   = last_good;
    end
    expq.push_back(x);
  endtask

  task automatic check_events(input string name);
    int n;
    checks++;
    if (evq.size() !== expq.size()) begin
      errors++;
      $display("FAIL %s event_count got %0d want %0d", name, evq.size(), expq.size());
    end
    n = (evq.size() < expq.size()) ? evq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (evq[i].is_err !== expq[i].is_err) begin
        errors++;
        $display("FAIL %s kind[%0d] got %0d want %0d", name, i, evq[i].is_err, expq[i].is_err);
      end
      checks++;
      if (evq[i].data !== expq[i].data) begin
        errors++;
        $display("FAIL %s data[%0d] got %h want %h", name, i, evq[i].data, expq[i].data);
      end
      checks++;
      if (evq[i].cyc !== expq[i].start + LAT) begin
        errors++;
        $display("FAIL %s latency[%0d] got %0d want %0d", name, i,
                 evq[i].cyc - expq[i].start, LAT);
      end
      checks++;
      if (evq[i].busy !== expq[i].is_err) begin
        errors++;
        $display("FAIL %s busy_at_strobe[%0d] got %b want %b", name, i, evq[i].busy,
                 expq[i].is_err);
      end
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(1'b1, 3);
    rst_n = 1'b1;
    @(negedge clk);
    check_byte("reset_data", o_data, 8'h00);
    check_bit("reset_valid", o_valid, 1'b0);
    check_bit("reset_frame_err", o_frame_err, 1'b0);
    check_bit("reset_busy", o_busy, 1'b0);
    last_good = 8'h00;
    evq.delete();
    expq.delete();
    idle(1'b1, 5);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(1'b1, 20);
    check_events("single_a5");
    check_byte("single_hold", o_data, 8'hA5);
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(1'b0, 40);
    check_bit("break_busy_low_line", o_busy, 1'b1);
    check_events("frame_err");
    idle(1'b1, 5);
    check_bit("break_exit_busy", o_busy, 1'b0);
    check_byte("frame_err_data_held", o_data, 8'hA5);
  endtask

  task automatic test_glitch();
    busy_seen = 1'b0;
    idle(1'b0, 3);
    idle(1'b1, 20);
    check_bit("glitch_busy_pulsed", busy_seen, 1'b1);
    check_bit("glitch_idle", o_busy, 1'b0);
    check_events("glitch_no_strobe");
  endtask

  task automatic test_back_to_back();
    int d;
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle(1'b1, 20);
    d = (evq.size() == 2) ? evq[1].cyc - evq[0].cyc : -1;
    checks++;
    if (d !== 10 * CPB) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want %0d", d, 10 * CPB);
    end
    check_events("back_to_back");
  endtask

  task automatic test_reset_mid();
    send_frame(8'h55, 1'b1, -1, 5 * CPB + CPB / 2);
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(1'b1, 2);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("midreset_busy", o_busy, 1'b0);
    check_byte("midreset_data", o_data, 8'h00);
    last_good = 8'h00;
    idle(1'b1, 5);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(1'b1, 20);
    check_events("reset_mid_frame");
  endtask

  task automatic test_majority();
    logic [7:0] want;
`ifdef CEREAL_RX_MAJORITY_EN
    want = 8'h00;
`else
    want = 8'h04;
`endif
    send_frame(8'h00, 1'b1, 3 * CPB + CPB / 2, -1);
    idle(1'b1, 20);
    check_byte("bit2_glitch_data", o_data, want);
    check_events("bit2_glitch");
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         stop;
    for (int i = 0; i < 12; i++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, -1, -1);
      if (stop) begin
        idle(1'b1, $urandom_range(0, 12));
      end else begin
        idle(1'b0, $urandom_range(1, 20));
        idle(1'b1, $urandom_range(1, 10));
      end
    end
    idle(1'b1, 20);
    check_events("random_frames");
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_majority();
    test_random();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL valid_and_frame_err_overlap got %0d want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
